// File: rtl/df_pkg.sv
// Shared select encoding and helpers for the df_mux4 selector family.
package df_pkg;

   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_I0 = 2'b00;
   localparam sel_t SEL_I1 = 2'b01;
   localparam sel_t SEL_I2 = 2'b10;
   localparam sel_t SEL_I3 = 2'b11;

   function automatic logic [3:0] sel_onehot(input sel_t s);
      logic [3:0] base;
      base = 4'b0001;
      return base << s;
   endfunction

endpackage

// File: rtl/df_mux4_comb.sv
// Pure AND-OR 4:1 selector, zero latency, no clock and no backpressure.
module df_mux4_comb #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             s1,
   input  logic             s0,
   output logic [WIDTH-1:0] y
);

   assign y = ({WIDTH{~s1 & ~s0}} & i0)
            | ({WIDTH{~s1 &  s0}} & i1)
            | ({WIDTH{ s1 & ~s0}} & i2)
            | ({WIDTH{ s1 &  s0}} & i3);

endmodule

// File: rtl/df_mux4.sv
// 4:1 dataflow mux: y at 0 latency, y_q/sel_q one cycle later; no backpressure.
// Optional DF_MUX_ONEHOT_EN adds sel_oh, a registered one-hot copy of the select.
module df_mux4
   import df_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             s1,
   input  logic             s0,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output sel_t             sel_q
`ifdef DF_MUX_ONEHOT_EN
   ,
   output logic [3:0]       sel_oh
`endif
);

   logic [WIDTH-1:0] y_d;
   sel_t             sel_d;

   df_mux4_comb #(.WIDTH(WIDTH)) u_comb (
      .i0 (i0),
      .i1 (i1),
      .i2 (i2),
      .i3 (i3),
      .s1 (s1),
      .s0 (s0),
      .y  (y)
   );

   always_comb begin
      y_d   = y;
      sel_d = {s1, s0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q   <= '0;
         sel_q <= SEL_I0;
      end else begin
         y_q   <= y_d;
         sel_q <= sel_d;
      end
   end

`ifdef DF_MUX_ONEHOT_EN
   // Decoded from the live select so it tracks sel_q cycle for cycle.
   logic [3:0] sel_oh_d;
   logic [3:0] sel_oh_q;

   always_comb begin
      sel_oh_d = sel_onehot(sel_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_oh_q <= sel_onehot(SEL_I0);
      end else begin
         sel_oh_q <= sel_oh_d;
      end
   end

   assign sel_oh = sel_oh_q;
`endif

endmodule

// File: tb/tb_df_mux4.sv
// Directed table-driven bench for df_mux4 at WIDTH=1 and WIDTH=8.
module tb_df_mux4;

   logic       clk;
   logic       rst;
   logic       s1, s0;
   logic       a0, a1, a2, a3;
   logic [7:0] b0, b1, b2, b3;
   logic       y1, y1_q;
   logic [7:0] y8, y8_q;
   logic [1:0] sel1_q, sel8_q;
`ifdef DF_MUX_ONEHOT_EN
   logic [3:0] oh1, oh8;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   df_mux4 #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .i0(a0), .i1(a1), .i2(a2), .i3(a3),
      .s1(s1), .s0(s0),
      .y(y1), .y_q(y1_q), .sel_q(sel1_q)
`ifdef DF_MUX_ONEHOT_EN
      , .sel_oh(oh1)
`endif
   );

   df_mux4 #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .i0(b0), .i1(b1), .i2(b2), .i3(b3),
      .s1(s1), .s0(s0),
      .y(y8), .y_q(y8_q), .sel_q(sel8_q)
`ifdef DF_MUX_ONEHOT_EN
      , .sel_oh(oh8)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  d1;    // {i3,i2,i1,i0} for WIDTH=1
      logic        exp1;
      logic [31:0] d8;    // {i3,i2,i1,i0} for WIDTH=8
      logic [7:0]  exp8;
      logic [3:0]  exp_oh;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setv(input int idx, input logic [1:0] sel, input logic [3:0] d1,
                       input logic e1, input logic [31:0] d8, input logic [7:0] e8,
                       input logic [3:0] eoh);
      vecs[idx].sel    = sel;
      vecs[idx].d1     = d1;
      vecs[idx].exp1   = e1;
      vecs[idx].d8     = d8;
      vecs[idx].exp8   = e8;
      vecs[idx].exp_oh = eoh;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [3:0] d1, input logic [31:0] d8);
      {s1, s0}         = sel;
      {a3, a2, a1, a0} = d1;
      {b3, b2, b1, b0} = d8;
   endtask

   initial begin
      // Default pattern i0=0, i1..i3=1, and the byte pattern A5/3C/F0/0F.
      setv(0,  2'b00, 4'b1110, 1'b1 ^ 1'b1, 32'h0FF03CA5, 8'hA5, 4'b0001);
      setv(1,  2'b01, 4'b1110, 1'b1, 32'h0FF03CA5, 8'h3C, 4'b0010);
      setv(2,  2'b10, 4'b1110, 1'b1, 32'h0FF03CA5, 8'hF0, 4'b0100);
      setv(3,  2'b11, 4'b1110, 1'b1, 32'h0FF03CA5, 8'h0F, 4'b1000);
      // Walking one: hot input i0, then i1, i2, i3; each against every select.
      setv(4,  2'b00, 4'b0001, 1'b1, 32'h000000FF, 8'hFF, 4'b0001);
      setv(5,  2'b01, 4'b0001, 1'b0, 32'h000000FF, 8'h00, 4'b0010);
      setv(6,  2'b10, 4'b0001, 1'b0, 32'h000000FF, 8'h00, 4'b0100);
      setv(7,  2'b11, 4'b0001, 1'b0, 32'h000000FF, 8'h00, 4'b1000);
      setv(8,  2'b00, 4'b0010, 1'b0, 32'h0000FF00, 8'h00, 4'b0001);
      setv(9,  2'b01, 4'b0010, 1'b1, 32'h0000FF00, 8'hFF, 4'b0010);
      setv(10, 2'b10, 4'b0010, 1'b0, 32'h0000FF00, 8'h00, 4'b0100);
      setv(11, 2'b11, 4'b0010, 1'b0, 32'h0000FF00, 8'h00, 4'b1000);
      setv(12, 2'b00, 4'b0100, 1'b0, 32'h00FF0000, 8'h00, 4'b0001);
      setv(13, 2'b01, 4'b0100, 1'b0, 32'h00FF0000, 8'h00, 4'b0010);
      setv(14, 2'b10, 4'b0100, 1'b1, 32'h00FF0000, 8'hFF, 4'b0100);
      setv(15, 2'b11, 4'b0100, 1'b0, 32'h00FF0000, 8'h00, 4'b1000);
      setv(16, 2'b00, 4'b1000, 1'b0, 32'hFF000000, 8'h00, 4'b0001);
      setv(17, 2'b01, 4'b1000, 1'b0, 32'hFF000000, 8'h00, 4'b0010);
      setv(18, 2'b10, 4'b1000, 1'b0, 32'hFF000000, 8'h00, 4'b0100);
      setv(19, 2'b11, 4'b1000, 1'b1, 32'hFF000000, 8'hFF, 4'b1000);

      rst = 1'b1;
      drive(2'b11, 4'b0000, 32'h0);
      #2;
      check("rst_y1_q",   32'(y1_q),   32'h0);
      check("rst_sel1_q", 32'(sel1_q), 32'h0);
      check("rst_y8_q",   32'(y8_q),   32'h0);
      check("rst_sel8_q", 32'(sel8_q), 32'h0);
`ifdef DF_MUX_ONEHOT_EN
      check("rst_sel_oh", 32'(oh1), 32'h1);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Zero-latency checks on y, then one-edge-later checks on the registers.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(vecs[k].sel, vecs[k].d1, vecs[k].d8);
         #1;
         check($sformatf("v%0d_y1", k), 32'(y1), 32'(vecs[k].exp1));
         check($sformatf("v%0d_y8", k), 32'(y8), 32'(vecs[k].exp8));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_y1_q", k),  32'(y1_q),   32'(vecs[k].exp1));
         check($sformatf("v%0d_y8_q", k),  32'(y8_q),   32'(vecs[k].exp8));
         check($sformatf("v%0d_sel_q", k), 32'(sel1_q), 32'(vecs[k].sel));
`ifdef DF_MUX_ONEHOT_EN
         check($sformatf("v%0d_sel_oh", k), 32'(oh8), 32'(vecs[k].exp_oh));
`endif
      end

      // Registered path: sel 00 -> 11 with i3=1, i0=0.
      @(negedge clk);
      drive(2'b00, 4'b1000, 32'h11000022);
      @(posedge clk);
      #1;
      check("reg_pre_y1_q", 32'(y1_q), 32'h0);
      check("reg_pre_y8_q", 32'(y8_q), 32'h22);
      @(negedge clk);
      drive(2'b11, 4'b1000, 32'h11000022);
      #1;
      check("reg_y1_now",  32'(y1),   32'h1);
      check("reg_y8_now",  32'(y8),   32'h11);
      check("reg_y1_lag",  32'(y1_q), 32'h0);
      @(posedge clk);
      #1;
      check("reg_y1_q",  32'(y1_q),   32'h1);
      check("reg_y8_q",  32'(y8_q),   32'h11);
      check("reg_sel_q", 32'(sel1_q), 32'h3);

      // Async reset mid-cycle, released before the next edge.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_y1_q",   32'(y1_q),   32'h0);
      check("arst_sel1_q", 32'(sel1_q), 32'h0);
      check("arst_y8_q",   32'(y8_q),   32'h0);
      check("arst_y1",     32'(y1),     32'h1);
`ifdef DF_MUX_ONEHOT_EN
      check("arst_sel_oh", 32'(oh1), 32'h1);
`endif
      rst = 1'b0;
      #1;
      check("hold_y1_q",   32'(y1_q),   32'h0);
      check("hold_sel1_q", 32'(sel1_q), 32'h0);
      @(posedge clk);
      #1;
      check("reload_y1_q",  32'(y1_q),   32'h1);
      check("reload_y8_q",  32'(y8_q),   32'h11);
      check("reload_sel_q", 32'(sel8_q), 32'h3);

`ifdef DF_MUX_ONEHOT_EN
      // Select 10 clocked in after a fresh reset.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("oh_rst", 32'(oh8), 32'h1);
      rst = 1'b0;
      drive(2'b10, 4'b0100, 32'h0);
      @(posedge clk);
      #1;
      check("oh_sel10", 32'(oh1), 32'h4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/df_mux4.md
Name: df_mux4

Overview:
- 4:1 multiplexer in dataflow style.
- Combinational output y selects one of four data inputs using the 2-bit select {s1,s0}.
- Registered copy y_q and registered select sel_q are provided for downstream synchronous logic.
- Used as a leaf data-path selector; y keeps zero latency so purely combinational users need no clock.

Parameters:
- WIDTH, 1, bit width of each data input and of y and y_q.

Ports:
- clk  input  1  system clock; y_q and sel_q update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i0  input  WIDTH  data input, selected when {s1,s0}=2'b00.
- i1  input  WIDTH  data input, selected when {s1,s0}=2'b01.
- i2  input  WIDTH  data input, selected when {s1,s0}=2'b10.
- i3  input  WIDTH  data input, selected when {s1,s0}=2'b11.
- s1  input  1  select MSB.
- s0  input  1  select LSB.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.
- sel_q  output  2  registered {s1,s0}.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-high (rst).
- y is pure dataflow with no clock dependency:
  - y = (~s1&~s0&i0) | (~s1&s0&i1) | (s1&~s0&i2) | (s1&s0&i3), applied per bit.
  - Latency is 0; y follows any change of a data or select input within the same delta/timestep.
- Reset:
  - While rst=1: y_q=0 and sel_q=2'b00. Assertion takes effect immediately, with no clock edge needed.
  - y is unaffected by rst.
- On a rising clk edge with rst=0: y_q <= y and sel_q <= {s1,s0}. y_q therefore lags y by exactly 1 cycle.
- Reset deasserted between edges: registers hold 0 until the next rising edge, then load normally.
- Simultaneous select and data change: y reflects the new select with the new data. No glitch-free guarantee on y. y_q samples whatever value is present at the edge.
- X/Z on a select bit: y may go X. Simulation-only behaviour; no X-resolution logic is required.
- No internal state other than y_q, sel_q and (optional) sel_oh_q.

Optional Feature:
- Macro: DF_MUX_ONEHOT_EN
- Defined: adds output sel_oh, 4 bits, one-hot decode of the registered select.
  - sel_oh[k]=1 iff sel_q==k.
  - Reset value 4'b0001, consistent with sel_q=00.
- Undefined: the sel_oh port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package df_pkg:
  - localparam SEL_W=2.
  - Select codes SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11.
  - Typedef sel_t of SEL_W bits.
- One natural sub-module, df_mux4_comb: the pure combinational WIDTH-bit AND-OR selector producing y.
- The top-level df_mux4 adds the reset registers and the optional one-hot decode.

Test Plan:
- Default stimulus: i0=0, i1=1, i2=1, i3=1, WIDTH=1. Step {s1,s0} through 00, 01, 10, 11 at 100 ns intervals -> y = 0, 1, 1, 1 with zero delay.
- Walking-one data: i0=1 with i1..i3=0, then each other input in turn. Each select code -> y=1 only when the select matches the hot input.
- Registered path: clocking with rst=0, change sel 00 -> 11 with i3=1, i0=0 -> y=1 immediately; y_q=1 and sel_q=11 one rising edge later.
- Async reset: with y_q=1, assert rst mid-cycle -> y_q=0 and sel_q=00 before any clock edge, while y stays 1. Deassert -> next edge reloads y_q=1.
- WIDTH=8, i0=8'hA5, i1=8'h3C, i2=8'hF0, i3=8'h0F: cycle through selects -> y equals the selected byte exactly.
- With DF_MUX_ONEHOT_EN defined: after reset sel_oh=4'b0001. Select 10 clocked in -> sel_oh=4'b0100.
